// File: rtl/axi_rw_phase_scheduler.sv
// ---------------------------------------------------------------------------
// axi_rw_phase_scheduler
//
// Picks the read or write direction for the shared AXI slave path. Only one
// direction is granted at a time. Each direction may issue up to its weight
// of consecutive addresses while the other direction is waiting. The number
// of issued-but-uncompleted transactions is capped. Before the direction
// turns around, every outstanding transaction is drained, so the memory
// behind the path sees clean read and write phases.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   wr_pending   at least one write requester is pending
//   rd_pending   at least one read requester is pending
//   addr_issue   pulse: AW/AR handshake completed in the current direction
//   txn_done     pulse: transaction completed (B, or R with rlast)
//   dir_valid    a direction is granted (state WR or RD)
//   rd_wr_flag   1 = write phase, 0 = read phase; holds its value in IDLE
//   issue_en     an address issue is permitted this cycle
//   outstanding  current count of outstanding transactions
//   err          sticky flag: protocol violation seen since reset
// ---------------------------------------------------------------------------
module axi_rw_phase_scheduler #(
  parameter int WR_WEIGHT       = 4,
  parameter int RD_WEIGHT       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_pending,
  input  logic             rd_pending,
  input  logic             addr_issue,
  input  logic             txn_done,
  output logic             dir_valid,
  output logic             rd_wr_flag,
  output logic             issue_en,
  output logic [OUT_W-1:0] outstanding,
  output logic             err
);

  localparam int MAX_WT = (WR_WEIGHT > RD_WEIGHT) ? WR_WEIGHT : RD_WEIGHT;
  localparam int BC_W   = $clog2(MAX_WT + 1);

  localparam logic [BC_W-1:0]  WR_WT   = BC_W'(WR_WEIGHT);
  localparam logic [BC_W-1:0]  RD_WT   = BC_W'(RD_WEIGHT);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    WR_DRAIN = 3'd2,
    RD       = 3'd3,
    RD_DRAIN = 3'd4
  } state_t;

  state_t           r_state;
  logic [BC_W-1:0]  r_burst_cnt;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_last_dir;   // 1 = last drained phase was write
  logic             r_rd_wr_flag;
  logic             r_err;

  logic             w_dir_valid;
  logic             w_in_wr;
  logic [BC_W-1:0]  w_weight;
  logic             w_own_pending;
  logic             w_other_pending;
  logic             w_yield;
  logic             w_issue_en;
  logic             w_issue_ok;
  logic             w_done_ok;
  logic             w_violation;
  logic [BC_W-1:0]  w_burst_inc;
  logic [BC_W-1:0]  w_burst_next;
  logic [OUT_W-1:0] w_out_next;

  // Direction-relative view so WR and RD share one set of equations.
  assign w_dir_valid     = (r_state == WR) || (r_state == RD);
  assign w_in_wr         = (r_state == WR);
  assign w_weight        = w_in_wr ? WR_WT : RD_WT;
  assign w_own_pending   = w_in_wr ? wr_pending : rd_pending;
  assign w_other_pending = w_in_wr ? rd_pending : wr_pending;

  // Once the weight is used up, further issues are held back only while the
  // other direction is actually waiting; otherwise the burst keeps going.
  assign w_yield    = (r_burst_cnt == w_weight) && w_other_pending;
  assign w_issue_en = w_dir_valid && (r_outstanding < MAX_OUT) && !w_yield;

  assign w_issue_ok  = addr_issue && w_issue_en;
  assign w_done_ok   = txn_done && (r_outstanding != '0);
  assign w_violation = (addr_issue && !w_issue_en) ||
                       (txn_done && (r_outstanding == '0));

  // burst_cnt < weight whenever it increments, so the +1 cannot overflow.
  assign w_burst_inc  = (r_burst_cnt == w_weight) ? r_burst_cnt
                                                  : r_burst_cnt + BC_W'(1);
  assign w_burst_next = w_issue_ok ? w_burst_inc : r_burst_cnt;

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_issue_ok, w_done_ok})
      2'b10:   w_out_next = r_outstanding + OUT_W'(1);
      2'b01:   w_out_next = r_outstanding - OUT_W'(1);
      default: w_out_next = r_outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_burst_cnt   <= '0;
      r_outstanding <= '0;
      r_last_dir    <= 1'b0;
      r_rd_wr_flag  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_violation) begin
        r_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_burst_cnt <= '0;
          // Tie-break alternates away from the last drained direction.
          if (wr_pending && (!rd_pending || !r_last_dir)) begin
            r_state      <= WR;
            r_rd_wr_flag <= 1'b1;
          end else if (rd_pending) begin
            r_state      <= RD;
            r_rd_wr_flag <= 1'b0;
          end
        end

        WR, RD: begin
          // With nothing pending at all the direction stays parked and keeps
          // its burst count.
          r_burst_cnt <= w_burst_next;
          if (w_other_pending &&
              ((w_burst_next == w_weight) || !w_own_pending)) begin
            r_state <= w_in_wr ? WR_DRAIN : RD_DRAIN;
          end
        end

        WR_DRAIN: begin
          if (r_outstanding == '0) begin
            r_last_dir  <= 1'b1;
            r_burst_cnt <= '0;
            if (rd_pending) begin
              r_state      <= RD;
              r_rd_wr_flag <= 1'b0;
            end else if (wr_pending) begin
              r_state <= WR;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        RD_DRAIN: begin
          if (r_outstanding == '0) begin
            r_last_dir  <= 1'b0;
            r_burst_cnt <= '0;
            if (wr_pending) begin
              r_state      <= WR;
              r_rd_wr_flag <= 1'b1;
            end else if (rd_pending) begin
              r_state <= RD;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  assign dir_valid   = w_dir_valid;
  assign rd_wr_flag  = r_rd_wr_flag;
  assign issue_en    = w_issue_en;
  assign outstanding = r_outstanding;
  assign err         = r_err;

endmodule

// File: tb/tb_axi_rw_phase_scheduler.sv
module tb_axi_rw_phase_scheduler;

  localparam int OUT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr_pending;
  logic             rd_pending;
  logic             addr_issue;
  logic             txn_done;
  logic             dir_valid;
  logic             rd_wr_flag;
  logic             issue_en;
  logic [OUT_W-1:0] outstanding;
  logic             err;

  int n_vec = 0;
  int n_err = 0;

  axi_rw_phase_scheduler #(
    .WR_WEIGHT      (4),
    .RD_WEIGHT      (4),
    .MAX_OUTSTANDING(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_pending (wr_pending),
    .rd_pending (rd_pending),
    .addr_issue (addr_issue),
    .txn_done   (txn_done),
    .dir_valid  (dir_valid),
    .rd_wr_flag (rd_wr_flag),
    .issue_en   (issue_en),
    .outstanding(outstanding),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dir_valid"}, 32'(dir_valid), 0);
    chk({tag, "_flag"}, 32'(rd_wr_flag), 0);
    chk({tag, "_issue_en"}, 32'(issue_en), 0);
    chk({tag, "_outstanding"}, 32'(outstanding), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    rstn       = 1'b1;
    wr_pending = 1'b0;
    rd_pending = 1'b0;
    addr_issue = 1'b0;
    txn_done   = 1'b0;
    #3 rstn = 1'b0;
    cyc();
    cyc();
    #1;
    chk_reset("reset");
    rstn = 1'b1;

    // Write-only flow: grant one cycle after wr_pending, never drains.
    wr_pending = 1'b1;
    #1 chk("wo_pre_grant", 32'(dir_valid), 0);
    cyc();
    #1;
    chk("wo_dir_valid", 32'(dir_valid), 1);
    chk("wo_flag", 32'(rd_wr_flag), 1);
    chk("wo_issue_en", 32'(issue_en), 1);
    for (int i = 0; i < 10; i++) begin
      addr_issue = 1'b1;
      txn_done   = (i != 0);
      #1;
      chk("wo_loop_issue_en", 32'(issue_en), 1);
      chk("wo_loop_dir_valid", 32'(dir_valid), 1);
      cyc();
    end
    addr_issue = 1'b0;
    txn_done   = 1'b1;
    #1 chk("wo_out_one", 32'(outstanding), 1);
    cyc();
    txn_done = 1'b0;
    #1;
    chk("wo_out_zero", 32'(outstanding), 0);
    chk("wo_err", 32'(err), 0);
    chk("wo_still_wr", 32'(dir_valid), 1);

    // Burst count saturated at 4: a rising rd_pending blocks issue at once.
    rd_pending = 1'b1;
    #1 chk("yield_issue_en", 32'(issue_en), 0);
    cyc();
    #1;
    chk("wr_drain_dir_valid", 32'(dir_valid), 0);
    chk("wr_drain_flag", 32'(rd_wr_flag), 1);
    chk("wr_drain_issue_en", 32'(issue_en), 0);
    cyc();
    #1;
    chk("rd_dir_valid", 32'(dir_valid), 1);
    chk("rd_flag", 32'(rd_wr_flag), 0);
    chk("rd_issue_en", 32'(issue_en), 1);

    // Weighted read burst; each issue completes two cycles later.
    for (int i = 0; i < 4; i++) begin
      addr_issue = 1'b1;
      txn_done   = (i >= 2);
      #1 chk("alt_rd_issue_en", 32'(issue_en), 1);
      cyc();
    end
    addr_issue = 1'b0;
    txn_done   = 1'b1;
    #1;
    chk("rd_drain_dir_valid", 32'(dir_valid), 0);
    chk("rd_drain_flag", 32'(rd_wr_flag), 0);
    chk("rd_drain_out2", 32'(outstanding), 2);
    cyc();
    #1;
    chk("rd_drain_hold", 32'(dir_valid), 0);
    chk("rd_drain_out1", 32'(outstanding), 1);
    cyc();
    txn_done = 1'b0;
    #1;
    chk("rd_drain_out0", 32'(outstanding), 0);
    chk("rd_drain_last", 32'(dir_valid), 0);
    cyc();
    #1;
    chk("alt_back_wr_valid", 32'(dir_valid), 1);
    chk("alt_back_wr_flag", 32'(rd_wr_flag), 1);

    // Write burst of 4 with no completions, then an illegal issue in drain.
    for (int i = 0; i < 4; i++) begin
      addr_issue = 1'b1;
      #1 chk("alt_wr_issue_en", 32'(issue_en), 1);
      cyc();
    end
    #1;
    chk("viol_drain_valid", 32'(dir_valid), 0);
    chk("viol_drain_issue_en", 32'(issue_en), 0);
    chk("viol_drain_out", 32'(outstanding), 4);
    chk("viol_drain_err_pre", 32'(err), 0);
    cyc();
    addr_issue = 1'b0;
    #1;
    chk("viol_drain_err", 32'(err), 1);
    chk("viol_drain_out_kept", 32'(outstanding), 4);
    txn_done = 1'b1;
    repeat (4) cyc();
    txn_done = 1'b0;
    #1;
    chk("wr_drained_out", 32'(outstanding), 0);
    chk("wr_drained_valid", 32'(dir_valid), 0);
    cyc();
    #1;
    chk("to_rd_valid", 32'(dir_valid), 1);
    chk("to_rd_flag", 32'(rd_wr_flag), 0);

    // Outstanding cap with reads only.
    wr_pending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr_issue = 1'b1;
      #1 chk("cap_issue_en", 32'(issue_en), 1);
      cyc();
    end
    addr_issue = 1'b0;
    #1;
    chk("cap_full_issue_en", 32'(issue_en), 0);
    chk("cap_full_out", 32'(outstanding), 8);
    chk("cap_full_valid", 32'(dir_valid), 1);
    txn_done = 1'b1;
    cyc();
    txn_done = 1'b0;
    #1;
    chk("cap_release_out", 32'(outstanding), 7);
    chk("cap_release_issue_en", 32'(issue_en), 1);
    txn_done = 1'b1;
    repeat (4) cyc();
    txn_done = 1'b0;
    #1 chk("sim_pre_out", 32'(outstanding), 3);

    // Issue and completion in the same cycle leave the count unchanged.
    addr_issue = 1'b1;
    txn_done   = 1'b1;
    #1 chk("sim_issue_en", 32'(issue_en), 1);
    cyc();
    addr_issue = 1'b0;
    txn_done   = 1'b0;
    #1;
    chk("sim_out", 32'(outstanding), 3);
    chk("err_sticky", 32'(err), 1);

    // Build up 5 outstanding and force a read drain.
    addr_issue = 1'b1;
    repeat (2) cyc();
    addr_issue = 1'b0;
    #1 chk("rst_pre_out", 32'(outstanding), 5);
    wr_pending = 1'b1;
    #1 chk("rst_pre_yield", 32'(issue_en), 0);
    cyc();
    #1;
    chk("rst_in_drain_valid", 32'(dir_valid), 0);
    chk("rst_in_drain_flag", 32'(rd_wr_flag), 0);
    chk("rst_in_drain_out", 32'(outstanding), 5);

    // Asynchronous reset mid-drain, checked before any clock edge.
    rstn = 1'b0;
    #1;
    chk_reset("async_rst");
    cyc();
    rstn = 1'b1;
    cyc();
    #1;
    chk("post_rst_valid", 32'(dir_valid), 1);
    chk("post_rst_flag_wr", 32'(rd_wr_flag), 1);

    // Completion with nothing outstanding.
    txn_done = 1'b1;
    cyc();
    txn_done = 1'b0;
    #1;
    chk("viol_done_err", 32'(err), 1);
    chk("viol_done_out", 32'(outstanding), 0);

    // Drain into IDLE: the phase flag holds its last value.
    wr_pending = 1'b0;
    cyc();
    #1 chk("to_idle_drain_valid", 32'(dir_valid), 0);
    rd_pending = 1'b0;
    cyc();
    #1;
    chk("idle_valid", 32'(dir_valid), 0);
    chk("idle_flag_hold", 32'(rd_wr_flag), 1);
    chk("idle_issue_en", 32'(issue_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
